// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter, plus the
// memory request/response message macros used by the arbiter ports.
`ifndef MEM_REQ
// Request: {type[2:0], opaque[o-1:0], addr[31:0], len[1:0], data[31:0]}
`define MEM_REQ(o) logic [3+(o)+32+2+32-1:0]
`endif
`ifndef MEM_RESP
// Response: {type[2:0], opaque[o-1:0], test[1:0], len[1:0], data[31:0]}
`define MEM_RESP(o) logic [3+(o)+2+2+32-1:0]
`endif

package mem_arb_pkg;

  typedef logic port_id_t;

  localparam port_id_t id_port0 = 1'b0;
  localparam port_id_t id_port1 = 1'b1;

  localparam int unsigned default_max_outstanding = 4;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Response-routing FIFO: remembers which upstream port issued each
// outstanding memory request, oldest first.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned depth = default_max_outstanding
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  port_id_t push_id,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output port_id_t head
);

  localparam int unsigned ptr_bits = $clog2(depth);
  localparam int unsigned cnt_bits = $clog2(depth + 1);

  port_id_t            ids [depth];
  logic [ptr_bits-1:0] wr_ptr;
  logic [ptr_bits-1:0] rd_ptr;
  logic [cnt_bits-1:0] count;
  logic                do_push;
  logic                do_pop;

  // A full FIFO never accepts a push, even when a pop frees a slot this cycle.
  assign full    = (count == cnt_bits'(depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = ids[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_bits'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_bits'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + cnt_bits'(1);
        2'b01:   count <= count - cnt_bits'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) ids[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/mem_arb_2port.sv
// Round-robin arbiter sharing one in-order memory port between an
// instruction port (0) and a data port (1), with ID-based response routing.
module mem_arb_2port
  import mem_arb_pkg::*;
#(
  parameter  int unsigned p_opaq_bits       = 8,
  parameter  int unsigned p_max_outstanding = default_max_outstanding,
  localparam int unsigned req_bits          = $bits(`MEM_REQ(p_opaq_bits)),
  localparam int unsigned resp_bits         = $bits(`MEM_RESP(p_opaq_bits))
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [req_bits-1:0]  req0_msg,
  input  logic                 req0_val,
  output logic                 req0_rdy,
  input  logic [req_bits-1:0]  req1_msg,
  input  logic                 req1_val,
  output logic                 req1_rdy,
  output logic [resp_bits-1:0] resp0_msg,
  output logic                 resp0_val,
  input  logic                 resp0_rdy,
  output logic [resp_bits-1:0] resp1_msg,
  output logic                 resp1_val,
  input  logic                 resp1_rdy,
  output logic [req_bits-1:0]  mem_req_msg,
  output logic                 mem_req_val,
  input  logic                 mem_req_rdy,
  input  logic [resp_bits-1:0] mem_resp_msg,
  input  logic                 mem_resp_val,
  output logic                 mem_resp_rdy
);

  port_id_t ptr;
  port_id_t head;
  port_id_t grant_id;
  logic     full;
  logic     empty;
  logic     grant0;
  logic     grant1;
  logic     req_fire;
  logic     resp_fire;

  // ptr names the favoured port when both request at once.
  assign grant0   = req0_val && (!req1_val || (ptr == id_port0));
  assign grant1   = req1_val && (!req0_val || (ptr == id_port1));
  assign grant_id = grant1 ? id_port1 : id_port0;

  assign mem_req_val = !rst && (req0_val || req1_val) && !full;
  assign mem_req_msg = grant1 ? req1_msg : req0_msg;
  assign req0_rdy    = !rst && grant0 && mem_req_rdy && !full;
  assign req1_rdy    = !rst && grant1 && mem_req_rdy && !full;
  assign req_fire    = mem_req_val && mem_req_rdy;

  // Responses are broadcast; only the port at the FIFO head sees valid.
  assign resp0_msg    = mem_resp_msg;
  assign resp1_msg    = mem_resp_msg;
  assign resp0_val    = !rst && mem_resp_val && !empty && (head == id_port0);
  assign resp1_val    = !rst && mem_resp_val && !empty && (head == id_port1);
  assign mem_resp_rdy = !rst && !empty && ((head == id_port1) ? resp1_rdy : resp0_rdy);
  assign resp_fire    = mem_resp_val && mem_resp_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= id_port0;
    end else if (req_fire) begin
      ptr <= (grant_id == id_port1) ? id_port0 : id_port1;
    end
  end

  mem_arb_id_fifo #(
    .depth (p_max_outstanding)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (req_fire),
    .push_id (grant_id),
    .pop     (resp_fire),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

endmodule

// File: tb/tb_mem_arb_2port.sv
// Scoreboard bench for mem_arb_2port: stimulus queues expected messages,
// a monitor pops and compares them on every channel fire.
module tb_mem_arb_2port;

  localparam int unsigned req_w  = 77;
  localparam int unsigned resp_w = 47;

  logic              clk;
  logic              rst;
  logic [req_w-1:0]  req0_msg, req1_msg, mem_req_msg;
  logic              req0_val, req0_rdy, req1_val, req1_rdy;
  logic [resp_w-1:0] resp0_msg, resp1_msg, mem_resp_msg;
  logic              resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic              mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;

  int total = 0;
  int bad   = 0;
  bit done  = 0;

  logic [req_w-1:0]  exp_req   [$];
  logic [resp_w-1:0] exp_resp0 [$];
  logic [resp_w-1:0] exp_resp1 [$];

  mem_arb_2port #(.p_opaq_bits(8), .p_max_outstanding(4)) dut (
    .clk(clk), .rst(rst),
    .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
    .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
    .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .mem_req_msg(mem_req_msg), .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_resp_msg(mem_resp_msg), .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [req_w-1:0] mk_req(input logic [31:0] addr);
    return {3'd0, addr[7:0], addr, 2'd0, 32'd0};
  endfunction

  function automatic logic [resp_w-1:0] mk_resp(input logic [31:0] data);
    return {3'd0, 8'h00, 2'd0, 2'd0, data};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Compares every fire against the oldest queued expectation.
  task automatic monitor();
    while (!done) begin
      @(negedge clk);
      if (mem_req_val && mem_req_rdy) begin
        chk("mem_req_expected", 128'(exp_req.size() > 0), 128'(1));
        if (exp_req.size() > 0) chk("mem_req_msg", 128'(mem_req_msg), 128'(exp_req.pop_front()));
      end
      if (resp0_val && resp0_rdy) begin
        chk("resp0_expected", 128'(exp_resp0.size() > 0), 128'(1));
        if (exp_resp0.size() > 0) chk("resp0_msg", 128'(resp0_msg), 128'(exp_resp0.pop_front()));
      end
      if (resp1_val && resp1_rdy) begin
        chk("resp1_expected", 128'(exp_resp1.size() > 0), 128'(1));
        if (exp_resp1.size() > 0) chk("resp1_msg", 128'(resp1_msg), 128'(exp_resp1.pop_front()));
      end
    end
  endtask

  task automatic stimulus();
    // Reset: outputs gated low even with live inputs.
    rst = 1'b1;
    req0_val = 1'b1; req0_msg = mk_req(32'h0);
    req1_val = 1'b1; req1_msg = mk_req(32'h4);
    mem_req_rdy = 1'b1;
    mem_resp_val = 1'b1; mem_resp_msg = mk_resp(32'hdead);
    resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    @(negedge clk);
    chk("rst_mem_req_val", 128'(mem_req_val), 128'(0));
    chk("rst_req0_rdy", 128'(req0_rdy), 128'(0));
    chk("rst_req1_rdy", 128'(req1_rdy), 128'(0));
    chk("rst_mem_resp_rdy", 128'(mem_resp_rdy), 128'(0));
    chk("rst_resp0_val", 128'(resp0_val), 128'(0));
    chk("rst_resp1_val", 128'(resp1_val), 128'(0));
    next();
    rst = 1'b0; req0_val = 1'b0; req1_val = 1'b0; mem_resp_val = 1'b0;
    next();

    // Contention from reset alternates 0,1,0; responses A,B,C route 0,1,0.
    req0_val = 1'b1; req0_msg = mk_req(32'h10);
    req1_val = 1'b1; req1_msg = mk_req(32'h20);
    exp_req.push_back(mk_req(32'h10));
    exp_req.push_back(mk_req(32'h20));
    exp_req.push_back(mk_req(32'h10));
    repeat (3) next();
    req0_val = 1'b0; req1_val = 1'b0;
    mem_resp_val = 1'b1;
    mem_resp_msg = mk_resp(32'hA); exp_resp0.push_back(mk_resp(32'hA)); next();
    mem_resp_msg = mk_resp(32'hB); exp_resp1.push_back(mk_resp(32'hB)); next();
    mem_resp_msg = mk_resp(32'hC); exp_resp0.push_back(mk_resp(32'hC)); next();
    mem_resp_val = 1'b0;

    // Port 1 alone, three back-to-back requests.
    req1_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req1_msg = mk_req(32'h100 + 32'(4 * i));
      exp_req.push_back(mk_req(32'h100 + 32'(4 * i)));
      next();
    end
    // ptr now favours port 0; this fire fills the FIFO (4 outstanding).
    req0_val = 1'b1; req0_msg = mk_req(32'h200);
    req1_msg = mk_req(32'h300);
    exp_req.push_back(mk_req(32'h200));
    next();

    // Fifth request stalls while full.
    req0_val = 1'b0;
    exp_req.push_back(mk_req(32'h300));
    repeat (2) begin
      @(negedge clk);
      chk("full_req1_rdy", 128'(req1_rdy), 128'(0));
      chk("full_req0_rdy", 128'(req0_rdy), 128'(0));
      chk("full_mem_req_val", 128'(mem_req_val), 128'(0));
      next();
    end
    // A pop while full must not let the request bypass in the same cycle.
    mem_resp_val = 1'b1; mem_resp_msg = mk_resp(32'h1100);
    exp_resp1.push_back(mk_resp(32'h1100));
    @(negedge clk);
    chk("nobypass_mem_req_val", 128'(mem_req_val), 128'(0));
    chk("nobypass_mem_resp_rdy", 128'(mem_resp_rdy), 128'(1));
    next();
    mem_resp_val = 1'b0;
    @(negedge clk);
    chk("after_pop_req1_rdy", 128'(req1_rdy), 128'(1));
    next();
    req1_val = 1'b0;

    // Head is port 1 with resp1_rdy low: 5 stalled cycles, delivery on the 6th.
    resp1_rdy = 1'b0; mem_resp_val = 1'b1; mem_resp_msg = mk_resp(32'h1104);
    repeat (5) begin
      @(negedge clk);
      chk("stall_mem_resp_rdy", 128'(mem_resp_rdy), 128'(0));
      chk("stall_resp1_val", 128'(resp1_val), 128'(1));
      chk("stall_resp0_val", 128'(resp0_val), 128'(0));
      next();
    end
    resp1_rdy = 1'b1; exp_resp1.push_back(mk_resp(32'h1104)); next();
    mem_resp_msg = mk_resp(32'h1108); exp_resp1.push_back(mk_resp(32'h1108)); next();
    mem_resp_msg = mk_resp(32'h1200); exp_resp0.push_back(mk_resp(32'h1200)); next();
    mem_resp_msg = mk_resp(32'h1300); exp_resp1.push_back(mk_resp(32'h1300)); next();

    // Response with nothing outstanding stalls.
    mem_resp_msg = mk_resp(32'hbad);
    @(negedge clk);
    chk("empty_resp0_val", 128'(resp0_val), 128'(0));
    chk("empty_resp1_val", 128'(resp1_val), 128'(0));
    chk("empty_mem_resp_rdy", 128'(mem_resp_rdy), 128'(0));
    next();
    mem_resp_val = 1'b0;

    // Two outstanding (ptr left at 1), then an asynchronous reset pulse.
    req0_val = 1'b1;
    req0_msg = mk_req(32'h400); exp_req.push_back(mk_req(32'h400)); next();
    req0_msg = mk_req(32'h404); exp_req.push_back(mk_req(32'h404)); next();
    req0_val = 1'b0;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    mem_resp_val = 1'b1; mem_resp_msg = mk_resp(32'hbad);
    @(negedge clk);
    chk("postrst_mem_resp_rdy", 128'(mem_resp_rdy), 128'(0));
    chk("postrst_resp0_val", 128'(resp0_val), 128'(0));
    chk("postrst_resp1_val", 128'(resp1_val), 128'(0));
    next();
    mem_resp_val = 1'b0;

    // Contention after reset grants port 0 first.
    req0_val = 1'b1; req0_msg = mk_req(32'h500);
    req1_val = 1'b1; req1_msg = mk_req(32'h600);
    exp_req.push_back(mk_req(32'h500));
    exp_req.push_back(mk_req(32'h600));
    repeat (2) next();
    req0_val = 1'b0; req1_val = 1'b0;
    mem_resp_val = 1'b1;
    mem_resp_msg = mk_resp(32'h1500); exp_resp0.push_back(mk_resp(32'h1500)); next();
    mem_resp_msg = mk_resp(32'h1600); exp_resp1.push_back(mk_resp(32'h1600)); next();
    mem_resp_val = 1'b0;
    repeat (2) next();
    done = 1'b1;
  endtask

  initial begin
    fork
      stimulus();
      monitor();
    join
    chk("left_mem_req", 128'(exp_req.size()), 128'(0));
    chk("left_resp0", 128'(exp_resp0.size()), 128'(0));
    chk("left_resp1", 128'(exp_resp1.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
